// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: FSM encoding, parameter
// defaults and the legal load-latency window.
package hazard_ctrl_pkg;

  localparam int RA_W_DEF     = 5;
  localparam int LOAD_LAT_DEF = 1;
  localparam int CNT_W_DEF    = 16;
  localparam int LOAD_LAT_MIN = 1;
  localparam int LOAD_LAT_MAX = 4;

  // Holds LOAD_LAT-1 for the largest legal latency.
  localparam int LD_CNT_W = $clog2(LOAD_LAT_MAX);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LD_WAIT  = 2'd1,
    ST_MDU_WAIT = 2'd2
  } state_t;

  typedef logic [LD_CNT_W-1:0] ld_cnt_t;

  function automatic ld_cnt_t ld_cnt_init(input int lat);
    return ld_cnt_t'(lat - 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller. The controller uses
// the slave view; the pipeline (or a bench) drives through the master view.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W  = RA_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic            id_ex_mem_read;
  logic [RA_W-1:0] id_ex_rt;
  logic [RA_W-1:0] if_id_rs;
  logic [RA_W-1:0] if_id_rt;
  logic            if_id_uses_rt;
  logic            if_id_is_mdu;
  logic            mdu_start;
  logic [RA_W-1:0] mdu_rd;
  logic            mdu_done;
  logic            branch_taken;
  logic            dmem_ready;
  logic            stat_clr;

  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             pipe_freeze;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt,
           if_id_is_mdu, mdu_start, mdu_rd, mdu_done, branch_taken,
           dmem_ready, stat_clr,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze,
           stall_cnt
  );

  modport master (
    output id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt,
           if_id_is_mdu, mdu_start, mdu_rd, mdu_done, branch_taken,
           dmem_ready, stat_clr,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze,
           stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Single-entry scoreboard for the outstanding multiply/divide result and the
// match of the ID-stage instruction against it.
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W = RA_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            mdu_start,
  input  logic [RA_W-1:0] mdu_rd,
  input  logic            mdu_done,
  input  logic [RA_W-1:0] if_id_rs,
  input  logic [RA_W-1:0] if_id_rt,
  input  logic            if_id_uses_rt,
  input  logic            if_id_is_mdu,
  output logic            hazard,
  output logic            releasing
);
  logic            busy_q, busy_d;
  logic [RA_W-1:0] dst_q, dst_d;

  // A new issue wins over a completion in the same cycle.
  always_comb begin
    busy_d = busy_q;
    dst_d  = dst_q;
    if (!hold) begin
      if (mdu_start) begin
        busy_d = 1'b1;
        dst_d  = mdu_rd;
      end else if (mdu_done) begin
        busy_d = 1'b0;
        dst_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      dst_q  <= '0;
    end else begin
      busy_q <= busy_d;
      dst_q  <= dst_d;
    end
  end

  assign releasing = busy_q && !busy_d;
  assign hazard    = busy_q && (if_id_is_mdu ||
                     ((dst_q != '0) && ((dst_q == if_id_rs) ||
                                        (if_id_uses_rt && (dst_q == if_id_rt)))));
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and MDU stalls, branch flush, memory
// freeze, plus a saturating count of cycles in which the PC was held.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W     = RA_W_DEF,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hif
);
  localparam ld_cnt_t LD_START = ld_cnt_init(LOAD_LAT);

  state_t           state_q, state_d;
  ld_cnt_t          ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic freeze, flush, ld_hazard, mdu_hazard, mdu_releasing, stall;
  logic pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze;

  assign freeze    = !hif.dmem_ready;
  assign flush     = hif.branch_taken && hif.dmem_ready;
  assign ld_hazard = hif.id_ex_mem_read && (hif.id_ex_rt != '0) &&
                     ((hif.id_ex_rt == hif.if_id_rs) ||
                      (hif.if_id_uses_rt && (hif.id_ex_rt == hif.if_id_rt)));

  hazard_scoreboard #(.RA_W(RA_W)) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .hold          (freeze),
    .mdu_start     (hif.mdu_start),
    .mdu_rd        (hif.mdu_rd),
    .mdu_done      (hif.mdu_done),
    .if_id_rs      (hif.if_id_rs),
    .if_id_rt      (hif.if_id_rt),
    .if_id_uses_rt (hif.if_id_uses_rt),
    .if_id_is_mdu  (hif.if_id_is_mdu),
    .hazard        (mdu_hazard),
    .releasing     (mdu_releasing)
  );

  always_comb begin
    state_d      = state_q;
    ld_cnt_d     = ld_cnt_q;
    stall        = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    pipe_freeze  = 1'b0;
    if (rst) begin
      // Registers are being cleared; present a free-running pipeline.
    end else if (freeze) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_freeze = 1'b1;
    end else if (flush) begin
      // The stalled consumer is squashed, so any pending wait is abandoned.
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
      state_d      = ST_IDLE;
      ld_cnt_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ld_hazard) begin
            stall = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d  = ST_LD_WAIT;
              ld_cnt_d = LD_START;
            end
          end else if (mdu_hazard) begin
            stall = 1'b1;
            if (!mdu_releasing) state_d = ST_MDU_WAIT;
          end
        end
        ST_LD_WAIT: begin
          stall    = 1'b1;
          ld_cnt_d = ld_cnt_q - ld_cnt_t'(1);
          if (ld_cnt_d == '0) state_d = ST_IDLE;
        end
        ST_MDU_WAIT: begin
          stall = 1'b1;
          if (mdu_releasing) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      if (stall) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hif.stat_clr)
      stall_cnt_d = '0;
    else if (!pc_write && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ld_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hif.pc_write     = pc_write;
  assign hif.if_id_write  = if_id_write;
  assign hif.id_ex_bubble = id_ex_bubble;
  assign hif.if_id_flush  = if_id_flush;
  assign hif.pipe_freeze  = pipe_freeze;
  assign hif.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: two controllers (LOAD_LAT=1 / CNT_W=16 and LOAD_LAT=3 /
// CNT_W=4); the unselected one sees an idle pipeline each cycle.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       mr;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       is_mdu;
    logic       mdu_start;
    logic [4:0] mdu_rd;
    logic       mdu_done;
    logic       branch;
    logic       dmem_ready;
    logic       stat_clr;
  } stim_t;

  typedef struct {
    string      nm;
    bit         sel;
    logic [4:0] o;
    int         cnt;
  } exp_t;

  // {pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze}
  localparam logic [4:0] RUN   = 5'b11000;
  localparam logic [4:0] STALL = 5'b00100;
  localparam logic [4:0] FRZ   = 5'b00001;
  localparam logic [4:0] FLUSH = 5'b11110;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  bit    sel = 1'b0;
  stim_t cur, in1, in3;
  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;
  int    cnt1 = 0;
  int    cnt3 = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.RA_W(5), .CNT_W(16)) hif1 ();
  hazard_ctrl_if #(.RA_W(5), .CNT_W(4))  hif3 ();

  hazard_ctrl #(.RA_W(5), .LOAD_LAT(1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .hif(hif1));
  hazard_ctrl #(.RA_W(5), .LOAD_LAT(3), .CNT_W(4))  dut3 (.clk(clk), .rst(rst), .hif(hif3));

  function automatic stim_t idle_stim();
    stim_t s;
    s = '0;
    s.dmem_ready = 1'b1;
    return s;
  endfunction

  always_comb begin
    in1 = idle_stim();
    in3 = idle_stim();
    if (sel) in3 = cur;
    else     in1 = cur;
  end

  assign hif1.id_ex_mem_read = in1.mr;        assign hif3.id_ex_mem_read = in3.mr;
  assign hif1.id_ex_rt       = in1.ex_rt;     assign hif3.id_ex_rt       = in3.ex_rt;
  assign hif1.if_id_rs       = in1.rs;        assign hif3.if_id_rs       = in3.rs;
  assign hif1.if_id_rt       = in1.rt;        assign hif3.if_id_rt       = in3.rt;
  assign hif1.if_id_uses_rt  = in1.uses_rt;   assign hif3.if_id_uses_rt  = in3.uses_rt;
  assign hif1.if_id_is_mdu   = in1.is_mdu;    assign hif3.if_id_is_mdu   = in3.is_mdu;
  assign hif1.mdu_start      = in1.mdu_start; assign hif3.mdu_start      = in3.mdu_start;
  assign hif1.mdu_rd         = in1.mdu_rd;    assign hif3.mdu_rd         = in3.mdu_rd;
  assign hif1.mdu_done       = in1.mdu_done;  assign hif3.mdu_done       = in3.mdu_done;
  assign hif1.branch_taken   = in1.branch;    assign hif3.branch_taken   = in3.branch;
  assign hif1.dmem_ready     = in1.dmem_ready; assign hif3.dmem_ready    = in3.dmem_ready;
  assign hif1.stat_clr       = in1.stat_clr;  assign hif3.stat_clr       = in3.stat_clr;

  logic [4:0] o1, o3;
  assign o1 = {hif1.pc_write, hif1.if_id_write, hif1.id_ex_bubble, hif1.if_id_flush, hif1.pipe_freeze};
  assign o3 = {hif3.pc_write, hif3.if_id_write, hif3.id_ex_bubble, hif3.if_id_flush, hif3.pipe_freeze};

  function automatic int upd(input int c, input int mx, input logic pc, input logic clr);
    if (clr) return 0;
    if (!pc && c < mx) return c + 1;
    return c;
  endfunction

  // Advance to just after the next rising edge and return inputs to idle.
  task automatic nxt();
    @(posedge clk);
    #1;
    cur = idle_stim();
  endtask

  // Queue the expected response of DUT s for the current cycle, then
  // advance the stall-count model past this cycle's edge.
  task automatic chk(input bit s, input string nm, input logic [4:0] o);
    exp_t e;
    if (rst) begin
      cnt1 = 0;
      cnt3 = 0;
    end
    e.nm  = nm;
    e.sel = s;
    e.o   = o;
    e.cnt = s ? cnt3 : cnt1;
    q.push_back(e);
    if (!rst) begin
      if (s) cnt3 = upd(cnt3, 15, o[4], (s == sel) && cur.stat_clr);
      else   cnt1 = upd(cnt1, 65535, o[4], (s == sel) && cur.stat_clr);
    end
  endtask

  initial begin : monitor
    exp_t       e;
    logic [4:0] act_o;
    int         act_c;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e     = q.pop_front();
        act_o = e.sel ? o3 : o1;
        act_c = e.sel ? int'(hif3.stall_cnt) : int'(hif1.stall_cnt);
        checks++;
        if (act_o !== e.o) begin
          errors++;
          $display("FAIL %s dut%0d outputs got %b want %b", e.nm, e.sel ? 3 : 1, act_o, e.o);
        end else
          $display("ok   %s dut%0d outputs %b", e.nm, e.sel ? 3 : 1, act_o);
        checks++;
        if (act_c != e.cnt) begin
          errors++;
          $display("FAIL %s dut%0d stall_cnt got %0d want %0d", e.nm, e.sel ? 3 : 1, act_c, e.cnt);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    cur = idle_stim();
    // Hazard and memory-not-ready applied while in reset: outputs stay free-running.
    nxt(); cur.mr = 1; cur.ex_rt = 5; cur.rs = 5; cur.dmem_ready = 0;
    chk(0, "rst_gate", RUN); chk(1, "rst_gate", RUN);
    nxt(); rst = 0;
    chk(0, "post_rst", RUN); chk(1, "post_rst", RUN);

    // LOAD_LAT=1 load-use on rs and rt, and the non-hazard variants.
    sel = 0;
    nxt(); cur.mr = 1; cur.ex_rt = 5; cur.rs = 5;           chk(0, "ld1_rs", STALL);
    nxt(); cur.rs = 5;                                      chk(0, "ld1_release", RUN);
    nxt(); cur.mr = 1; cur.ex_rt = 0; cur.rs = 0;           chk(0, "ld1_r0", RUN);
    nxt(); cur.mr = 1; cur.ex_rt = 6; cur.rt = 6;           chk(0, "ld1_rt_unused", RUN);
    nxt(); cur.mr = 1; cur.ex_rt = 6; cur.rt = 6; cur.uses_rt = 1; chk(0, "ld1_rt", STALL);
    nxt();                                                  chk(0, "ld1_rt_release", RUN);
    nxt(); cur.ex_rt = 5; cur.rs = 5;                       chk(0, "not_load", RUN);

    // MDU result r9 consumed while outstanding; done six cycles after start.
    nxt(); cur.mdu_start = 1; cur.mdu_rd = 9; cur.rs = 9;   chk(0, "mdu_issue", RUN);
    for (int i = 1; i <= 5; i++) begin
      nxt(); cur.rs = 9;                                    chk(0, "mdu_wait", STALL);
    end
    nxt(); cur.rs = 9; cur.mdu_done = 1;                    chk(0, "mdu_done", STALL);
    nxt(); cur.rs = 9;                                      chk(0, "mdu_release", RUN);
    // MDU-class consumer, then back-to-back issue/complete keeps it busy.
    nxt(); cur.mdu_start = 1; cur.mdu_rd = 3;               chk(0, "mdu2_issue", RUN);
    nxt(); cur.is_mdu = 1;                                  chk(0, "mdu2_is_mdu", STALL);
    nxt(); cur.mdu_start = 1; cur.mdu_done = 1; cur.mdu_rd = 4; cur.rs = 4; chk(0, "mdu2_swap", STALL);
    nxt(); cur.rs = 4;                                      chk(0, "mdu2_wait", STALL);
    nxt(); cur.rs = 4; cur.mdu_done = 1;                    chk(0, "mdu2_done", STALL);
    nxt(); cur.rs = 4;                                      chk(0, "mdu2_release", RUN);

    // LOAD_LAT=3: exactly three stalls for a load-use on rt.
    sel = 1;
    nxt(); cur.mr = 1; cur.ex_rt = 7; cur.rt = 7; cur.uses_rt = 1; chk(1, "ld3_s1", STALL);
    nxt();                                                  chk(1, "ld3_s2", STALL);
    nxt();                                                  chk(1, "ld3_s3", STALL);
    nxt();                                                  chk(1, "ld3_release", RUN);

    // Taken branch aborts LD_WAIT.
    nxt(); cur.mr = 1; cur.ex_rt = 7; cur.rt = 7; cur.uses_rt = 1; chk(1, "flush_ld", STALL);
    nxt(); cur.branch = 1;                                  chk(1, "flush", FLUSH);
    nxt();                                                  chk(1, "flush_idle", RUN);

    // Memory freeze mid LD_WAIT holds the countdown; a branch under freeze is ignored.
    nxt(); cur.mr = 1; cur.ex_rt = 7; cur.rs = 7;           chk(1, "frz_ld", STALL);
    nxt();                                                  chk(1, "frz_ld_w1", STALL);
    for (int i = 0; i < 4; i++) begin
      nxt(); cur.dmem_ready = 0; cur.branch = (i == 1);     chk(1, "frz", FRZ);
    end
    nxt();                                                  chk(1, "frz_ld_w2", STALL);
    nxt();                                                  chk(1, "frz_release", RUN);

    // Counter saturation at 15, clear under stall, reset inside LD_WAIT.
    for (int i = 0; i < 3; i++) begin
      nxt(); cur.dmem_ready = 0;                            chk(1, "sat_fill", FRZ);
    end
    nxt(); cur.mr = 1; cur.ex_rt = 2; cur.rs = 2;           chk(1, "sat_s1", STALL);
    nxt();                                                  chk(1, "sat_s2", STALL);
    nxt();                                                  chk(1, "sat_s3", STALL);
    nxt();                                                  chk(1, "sat_max", RUN);
    nxt(); cur.mr = 1; cur.ex_rt = 2; cur.rs = 2; cur.stat_clr = 1; chk(1, "clr_stall", STALL);
    nxt();                                                  chk(1, "clr_after", STALL);
    nxt(); rst = 1;                                         chk(1, "rst_mid_ld", RUN);
    nxt(); rst = 0;                                         chk(1, "rst_dropped", RUN);
    chk(0, "rst_dut1", RUN);

    nxt();
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never compared, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameters: RA_W, default 5, register-address width; LOAD_LAT, default 1, load-use stall cycles (legal range 1..4); CNT_W, default 16, stall-counter width.
REQ-002 SHALL have ports, in order: clk  in  1  sole clock; rst  in  1  asynchronous active-high reset.
REQ-003 SHALL have ports: id_ex_mem_read  in  1  EX-stage instruction is a load; id_ex_rt  in  RA_W  load destination register.
REQ-004 SHALL have ports: if_id_rs  in  RA_W  ID source register; if_id_rt  in  RA_W  ID second source; if_id_uses_rt  in  1  ID instruction reads rt; if_id_is_mdu  in  1  ID instruction is a multiply/divide.
REQ-005 SHALL have ports: mdu_start  in  1  MDU op issued this cycle; mdu_rd  in  RA_W  MDU destination register; mdu_done  in  1  MDU result written this cycle.
REQ-006 SHALL have ports: branch_taken  in  1  EX resolved a taken branch or jump; dmem_ready  in  1  data memory completes the access this cycle; stat_clr  in  1  clear the stall counter.
REQ-007 SHALL have outputs: pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze (each 1 bit); stall_cnt  CNT_W  saturating stall-cycle count.

Function
REQ-008 SHALL define the ID/EX hazard as: id_ex_mem_read, id_ex_rt != 0, and (id_ex_rt == if_id_rs, or if_id_uses_rt and id_ex_rt == if_id_rt).
REQ-009 SHALL implement a three-state FSM with states IDLE, LD_WAIT and MDU_WAIT; reset state IDLE.
REQ-010 In IDLE, a detected hazard SHALL stall that cycle. If LOAD_LAT > 1, the FSM SHALL enter LD_WAIT with ld_cnt = LOAD_LAT-1.
REQ-011 In LD_WAIT, the block SHALL stall every cycle and decrement ld_cnt. It SHALL return to IDLE on the edge where ld_cnt reaches 0, giving exactly LOAD_LAT stall cycles per hazard.
REQ-012 SHALL keep a scoreboard {mdu_busy, mdu_dst}. It is set on mdu_start at the clock edge and cleared on the edge where mdu_done=1. mdu_start and mdu_done in the same cycle SHALL leave it set with the new mdu_dst.
REQ-013 An MDU hazard SHALL exist when mdu_busy and (if_id_is_mdu, or mdu_dst != 0 and mdu_dst matches if_id_rs, or mdu_dst matches if_id_rt with if_id_uses_rt). During an MDU hazard the FSM SHALL sit in MDU_WAIT and stall. It SHALL exit to IDLE on the edge that clears mdu_busy.
REQ-014 Stall SHALL mean pc_write=0, if_id_write=0 and id_ex_bubble=1.
REQ-015 SHALL drive pipe_freeze=1, pc_write=0 and if_id_write=0 whenever dmem_ready=0, with id_ex_bubble=0 and if_id_flush=0. In that cycle the FSM, ld_cnt and the scoreboard set/clear SHALL hold.
REQ-016 branch_taken with dmem_ready=1 SHALL assert if_id_flush=1 and id_ex_bubble=1 and force pc_write=1. It SHALL abort LD_WAIT/MDU_WAIT to IDLE, because the stalled consumer is discarded. The scoreboard SHALL be unaffected.
REQ-017 Priority SHALL be, highest first: freeze, then flush, then load stall or MDU stall.
REQ-018 With no condition active, outputs SHALL be pc_write=1, if_id_write=1, all others 0.
REQ-019 stall_cnt SHALL increment on every edge where pc_write=0. It SHALL saturate at 2^CNT_W-1. stat_clr SHALL zero it, with priority over increment.
REQ-020 All outputs except stall_cnt SHALL be combinational from inputs and registered state, with zero cycles of latency.

Reset
REQ-021 rst=1 SHALL asynchronously force: FSM to IDLE, ld_cnt=0, mdu_busy=0, mdu_dst=0, stall_cnt=0.
REQ-022 During rst=1, outputs SHALL be pc_write=1, if_id_write=1, all others 0. A hazard pending at reset SHALL be dropped and not resumed.

Structure
REQ-023 The FSM state encoding and LOAD_LAT legal bounds SHALL live in the shared core package, with default parameter values.
REQ-024 The MDU scoreboard SHALL be one sub-module, hazard_scoreboard, holding {busy, dst} and providing the match logic.

Verification
REQ-025 LOAD_LAT=1: load to r5 in EX, ID reads rs=5 -> one stall cycle, then pc_write=1; same with id_ex_rt=0 -> no stall.
REQ-026 LOAD_LAT=3: load to r7, ID reads rt=7 with if_id_uses_rt=1 -> exactly 3 consecutive stall cycles; stall_cnt=3.
REQ-027 mdu_start with mdu_rd=9, consumer of r9 in ID, mdu_done 6 cycles later -> stalled through the done cycle, released the following cycle.
REQ-028 LD_WAIT active and branch_taken=1 -> if_id_flush=1, id_ex_bubble=1, pc_write=1, FSM IDLE next cycle.
REQ-029 dmem_ready=0 for 4 cycles during LOAD_LAT=3 stall -> pipe_freeze=1 for 4 cycles; ld_cnt holds; the remaining stalls complete after ready.
REQ-030 stall_cnt at 2^CNT_W-2 plus 3 stall cycles -> saturates at max; stat_clr with stall -> 0; rst mid-LD_WAIT -> IDLE, stall_cnt=0.
